// File: rtl/multi_debouncer_if.sv
// Button-side bundle for multi_debouncer: raw levels in, debounced levels and pulses out.
interface multi_debouncer_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0] pb_in;
    logic [N_CH-1:0] pb_state;
    logic [N_CH-1:0] press_pulse;
    logic [N_CH-1:0] release_pulse;
    logic [N_CH-1:0] hold_pulse;

    modport master (
        output pb_in,
        input  pb_state,
        input  press_pulse,
        input  release_pulse,
        input  hold_pulse
    );

    modport slave (
        input  pb_in,
        output pb_state,
        output press_pulse,
        output release_pulse,
        output hold_pulse
    );
endinterface

// File: rtl/multi_debouncer.sv
// N independent push-button debouncers with synchronisers, press/release edge pulses
// and an optional long-hold pulse; every output comes straight from a flop.

module multi_debouncer_checker #(
    parameter int N_CH        = 4,
    parameter int HOLD_CYCLES = 0
) (
    input logic            clk,
    input logic            reset,
    input logic [N_CH-1:0] pb_state,
    input logic [N_CH-1:0] press_pulse,
    input logic [N_CH-1:0] release_pulse,
    input logic [N_CH-1:0] hold_pulse
);
    a_press_release_exclusive: assert property (@(posedge clk) disable iff (reset)
        (press_pulse & release_pulse) == {N_CH{1'b0}});

    a_press_implies_high: assert property (@(posedge clk) disable iff (reset)
        (press_pulse & ~pb_state) == {N_CH{1'b0}});

    a_release_implies_low: assert property (@(posedge clk) disable iff (reset)
        (release_pulse & pb_state) == {N_CH{1'b0}});

    a_hold_implies_high: assert property (@(posedge clk) disable iff (reset)
        (hold_pulse & ~pb_state) == {N_CH{1'b0}});

    a_hold_disabled: assert property (@(posedge clk) disable iff (reset)
        (HOLD_CYCLES != 0) || (hold_pulse == {N_CH{1'b0}}));
endmodule

module multi_debouncer #(
    parameter int N_CH          = 4,
    parameter int STABLE_CYCLES = 1048576,
    parameter int SYNC_STAGES   = 2,
    parameter int HOLD_CYCLES   = 0
) (
    input logic              clk,
    input logic              reset,
    multi_debouncer_if.slave bus
);
    localparam int CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [N_CH-1:0] state_v;
    logic [N_CH-1:0] press_v;
    logic [N_CH-1:0] release_v;
    logic [N_CH-1:0] hold_v;

    genvar ch;
    for (ch = 0; ch < N_CH; ch++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_chain_r;
        logic [CNT_W-1:0]       cnt_r;
        logic                   state_r;
        logic                   press_r;
        logic                   release_r;
        logic                   sync_s;
        logic                   differ_s;
        logic                   accept_s;

        assign sync_s = sync_chain_r[SYNC_STAGES-1];

        // Metastability chain; the MSB is the only stage the debouncer looks at
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sync_chain_r <= {SYNC_STAGES{1'b0}};
            end else begin
                sync_chain_r <= {sync_chain_r[SYNC_STAGES-2:0], bus.pb_in[ch]};
            end
        end

        // A new level is accepted on the STABLE_CYCLES-th consecutive disagreeing sample
        always_comb begin
            differ_s = 1'b0;
            accept_s = 1'b0;
            if (sync_s != state_r) begin
                differ_s = 1'b1;
                if (cnt_r == CNT_LAST) begin
                    accept_s = 1'b1;
                end else begin
                    accept_s = 1'b0;
                end
            end else begin
                differ_s = 1'b0;
                accept_s = 1'b0;
            end
        end

        // Stability counter, debounced level and edge pulses; any agreeing sample restarts the count
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt_r     <= CNT_ZERO;
                state_r   <= 1'b0;
                press_r   <= 1'b0;
                release_r <= 1'b0;
            end else begin
                if (accept_s) begin
                    cnt_r   <= CNT_ZERO;
                    state_r <= ~state_r;
                end else if (differ_s) begin
                    cnt_r   <= cnt_r + CNT_ONE;
                    state_r <= state_r;
                end else begin
                    cnt_r   <= CNT_ZERO;
                    state_r <= state_r;
                end
                press_r   <= accept_s & ~state_r;
                release_r <= accept_s & state_r;
            end
        end

        if (HOLD_CYCLES > 0) begin : g_hold
            localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
            localparam logic [HOLD_W-1:0] HOLD_ZERO = HOLD_W'(0);
            localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
            localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
            localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(HOLD_CYCLES);

            logic [HOLD_W-1:0] hold_cnt_r;
            logic              hold_r;

            // Hold timer parks at HOLD_SAT so the pulse fires once per press; a release
            // accepted on the threshold edge wins over the hold
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    hold_cnt_r <= HOLD_ZERO;
                    hold_r     <= 1'b0;
                end else begin
                    if (!state_r) begin
                        hold_cnt_r <= HOLD_ZERO;
                    end else if (hold_cnt_r != HOLD_SAT) begin
                        hold_cnt_r <= hold_cnt_r + HOLD_ONE;
                    end else begin
                        hold_cnt_r <= hold_cnt_r;
                    end
                    hold_r <= state_r & ~accept_s & (hold_cnt_r == HOLD_LAST);
                end
            end

            assign hold_v[ch] = hold_r;
        end else begin : g_no_hold
            assign hold_v[ch] = 1'b0;
        end

        assign state_v[ch]   = state_r;
        assign press_v[ch]   = press_r;
        assign release_v[ch] = release_r;
    end

    assign bus.pb_state      = state_v;
    assign bus.press_pulse   = press_v;
    assign bus.release_pulse = release_v;
    assign bus.hold_pulse    = hold_v;

    multi_debouncer_checker #(
        .N_CH        (N_CH),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_checker (
        .clk           (clk),
        .reset         (reset),
        .pb_state      (state_v),
        .press_pulse   (press_v),
        .release_pulse (release_v),
        .hold_pulse    (hold_v)
    );
endmodule

// File: doc/multi_debouncer.md
MULTI_DEBOUNCER -- requirements
Module: multi_debouncer

Interface
REQ-001 Parameter N_CH, default 4: number of independent push-button channels (1..32).
REQ-002 Parameter STABLE_CYCLES, default 1048576: consecutive disagreeing samples required to accept a new level (>= 2).
REQ-003 Parameter SYNC_STAGES, default 2: input synchroniser depth (>= 2).
REQ-004 Parameter HOLD_CYCLES, default 0: accepted-high duration that fires hold_pulse; 0 disables hold detection.
REQ-005 clk  input  1  single system clock, all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 pb_in  input  N_CH  raw, asynchronous, bouncing button levels.
REQ-008 pb_state  output  N_CH  debounced level per channel, registered.
REQ-009 press_pulse  output  N_CH  one-cycle pulse on accepted 0->1 transition.
REQ-010 release_pulse  output  N_CH  one-cycle pulse on accepted 1->0 transition.
REQ-011 hold_pulse  output  N_CH  one-cycle pulse when pb_state has been 1 for HOLD_CYCLES cycles.

Function
REQ-012 Each channel shall be fully independent; no channel's input shall affect another channel's outputs.
REQ-013 Each pb_in bit shall pass through a SYNC_STAGES-deep flop chain; only the last stage (sync) feeds the debounce logic.
REQ-014 Per channel, a counter of width $clog2(STABLE_CYCLES) shall increment on every edge where sync != pb_state and clear to 0 on every edge where sync == pb_state.
REQ-015 On the edge where sync != pb_state and counter == STABLE_CYCLES-1, pb_state shall toggle and the counter shall clear to 0; the counter shall never wrap.
REQ-016 Latency: a clean input step shall appear on pb_state exactly SYNC_STAGES + STABLE_CYCLES rising edges after the first edge sampling the new level.
REQ-017 Any glitch returning sync to pb_state before acceptance shall restart the count from 0 (no partial credit).
REQ-018 press_pulse/release_pulse shall be registered, asserted for exactly the one cycle following the pb_state toggle, and never both high on the same channel.
REQ-019 Per channel, a hold counter shall count cycles while pb_state == 1, saturate after firing, and clear when pb_state == 0.
REQ-020 hold_pulse shall assert for one cycle when the hold counter reaches HOLD_CYCLES-1 with pb_state still 1; at most once per press; constant 0 when HOLD_CYCLES == 0.
REQ-021 A release accepted on the same edge the hold threshold would be reached shall suppress hold_pulse.
REQ-022 All outputs shall be driven from flops; no combinational path from pb_in to any output.

Reset
REQ-023 reset asserted shall asynchronously clear all synchroniser flops, debounce counters, hold counters, pb_state, press_pulse, release_pulse, hold_pulse to 0.
REQ-024 Reset asserted mid-count shall discard the partial count; after release, counting restarts from 0 against pb_state = 0.
REQ-025 A button held high through reset deassertion shall produce pb_state = 1 and one press_pulse after SYNC_STAGES + STABLE_CYCLES edges.

Verification (N_CH=2, STABLE_CYCLES=4, SYNC_STAGES=2, HOLD_CYCLES=10)
REQ-026 Clean step: pb_in[0] 0->1 held -> pb_state[0]=1 on 6th edge, press_pulse[0] high one cycle next cycle, channel 1 unchanged.
REQ-027 Bounce: pb_in[0] toggles 1,0,1,0 each cycle then held 1 -> no pulses during bounce; pb_state[0]=1 exactly 6 edges after the final rising sample.
REQ-028 Hold: pb_in[1] held high 20 cycles after acceptance -> exactly one hold_pulse[1], 10 cycles after pb_state[1] rose; release -> one release_pulse[1].
REQ-029 Short press: pb_in[0] high for 3 synced cycles then low -> pb_state[0] stays 0, no pulses.
REQ-030 Reset mid-operation: reset asserted 2 cycles into a count with pb_in[0]=1 -> all outputs 0 immediately; after deassert, press_pulse[0] after 6 edges.
REQ-031 Simultaneous: both channels stepped same cycle, ch1 opposite direction -> press_pulse[0] and release_pulse[1] (from pb_state[1]=1) in the same cycle.
